vga_line_fetch: RTL

- Upstream feeder of the VGA scan-out stage. Runs in the memory clock domain.
- Watches the scan-out's line request (read_buff_req / read_buff_A_B / read_buff_addr, generated in the pixel-clock domain) and fetches one display line from the frame buffer using burst reads.
- Writes the fetched pixels into line buffer A or B through their write ports. Those are dual-clock RAMs whose read ports belong to the scan-out stage.

---
 rtl/vga_line_fetch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_line_fetch.sv
// Memory-side line fetcher for VGA scan-out: turns a pixel-domain line request into burst reads
// and writes the returned pixels into line buffer A or B. Optional overrun counter: VGA_FETCH_OVERRUN_CNT_EN.
module vga_line_fetch #(
  parameter int ADDR_W           = 24,
  parameter int BURST_LEN        = 128,
  parameter int LINE_STRIDE_LOG2 = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              vga_mode,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic              read_buff_req,
  input  logic              read_buff_A_B,
  input  logic [9:0]        read_buff_addr,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [15:0]       mem_rd_data,
  output logic              buff_wr_en_A,
  output logic              buff_wr_en_B,
  output logic [9:0]        buff_wr_addr,
  output logic [15:0]       buff_wr_data,
  output logic              busy,
  output logic              line_done,
`ifdef VGA_FETCH_OVERRUN_CNT_EN
  input  logic              overrun_clr,
  output logic [15:0]       overrun_cnt,
`endif
  output logic              overrun
);

  localparam int NB_640    = 640 / BURST_LEN;
  localparam int NB_1024   = 1024 / BURST_LEN;
  localparam int WORD_W    = $clog2(BURST_LEN + 1);
  localparam int BCNT_W    = $clog2(NB_1024 + 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t              state_reg;
  logic                req_s1_reg, req_s2_reg, req_s3_reg;
  logic                mode_s1_reg, mode_s2_reg;
  logic                tgt_reg;
  logic [ADDR_W-1:0]   line_addr_reg;
  logic [9:0]          x_reg;
  logic [WORD_W-1:0]   word_cnt_reg;
  logic [BCNT_W-1:0]   burst_cnt_reg;
  logic [BCNT_W-1:0]   nbursts_reg;
  logic                mem_rd_req_reg;
  logic [ADDR_W-1:0]   mem_rd_addr_reg;
  logic [1:0]          wr_en_reg;
  logic [9:0]          wr_addr_reg;
  logic [15:0]         wr_data_reg;
  logic                line_done_reg;
  logic                overrun_reg;

  logic                req_edge;
  logic [ADDR_W-1:0]   accept_addr;

  assign req_edge    = req_s2_reg & ~req_s3_reg;
  // Wrap past the top of the address space is intentional and silent.
  assign accept_addr = frame_base + (ADDR_W'(read_buff_addr) << LINE_STRIDE_LOG2);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg       <= IDLE;
      req_s1_reg      <= 1'b0;
      req_s2_reg      <= 1'b0;
      req_s3_reg      <= 1'b0;
      mode_s1_reg     <= 1'b0;
      mode_s2_reg     <= 1'b0;
      tgt_reg         <= 1'b0;
      line_addr_reg   <= '0;
      x_reg           <= '0;
      word_cnt_reg    <= '0;
      burst_cnt_reg   <= '0;
      nbursts_reg     <= '0;
      mem_rd_req_reg  <= 1'b0;
      mem_rd_addr_reg <= '0;
      wr_en_reg       <= 2'b00;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      line_done_reg   <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      req_s1_reg    <= read_buff_req;
      req_s2_reg    <= req_s1_reg;
      req_s3_reg    <= req_s2_reg;
      mode_s1_reg   <= vga_mode;
      mode_s2_reg   <= mode_s1_reg;
      wr_en_reg     <= 2'b00;
      line_done_reg <= 1'b0;
      overrun_reg   <= req_edge && (state_reg != IDLE);

      case (state_reg)
        IDLE: begin
          if (req_edge) begin
            tgt_reg         <= read_buff_A_B;
            line_addr_reg   <= accept_addr;
            mem_rd_addr_reg <= accept_addr;
            nbursts_reg     <= mode_s2_reg ? BCNT_W'(NB_1024) : BCNT_W'(NB_640);
            x_reg           <= '0;
            burst_cnt_reg   <= '0;
            mem_rd_req_reg  <= 1'b1;
            state_reg       <= REQ;
          end
        end
        REQ: begin
          if (mem_rd_ack) begin
            mem_rd_req_reg <= 1'b0;
            word_cnt_reg   <= '0;
            state_reg      <= DATA;
          end
        end
        DATA: begin
          if (mem_rd_valid) begin
            wr_en_reg    <= tgt_reg ? 2'b10 : 2'b01;
            wr_addr_reg  <= x_reg;
            wr_data_reg  <= mem_rd_data;
            x_reg        <= x_reg + 10'd1;
            word_cnt_reg <= word_cnt_reg + WORD_W'(1);
            if (word_cnt_reg == WORD_W'(BURST_LEN - 1)) begin
              burst_cnt_reg <= burst_cnt_reg + BCNT_W'(1);
              if (burst_cnt_reg == nbursts_reg - BCNT_W'(1)) begin
                state_reg <= DONE;
              end else begin
                mem_rd_req_reg  <= 1'b1;
                mem_rd_addr_reg <= line_addr_reg + ADDR_W'(x_reg) + ADDR_W'(1);
                state_reg       <= REQ;
              end
            end
          end
        end
        DONE: begin
          line_done_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef VGA_FETCH_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt_reg;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      overrun_cnt_reg <= '0;
    end else if (overrun_clr) begin
      overrun_cnt_reg <= '0;
    end else if (overrun_reg && (overrun_cnt_reg != 16'hFFFF)) begin
      overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
    end
  end

  assign overrun_cnt = overrun_cnt_reg;
`endif

  assign mem_rd_req   = mem_rd_req_reg;
  assign mem_rd_addr  = mem_rd_addr_reg;
  assign buff_wr_en_A = wr_en_reg[0];
  assign buff_wr_en_B = wr_en_reg[1];
  assign buff_wr_addr = wr_addr_reg;
  assign buff_wr_data = wr_data_reg;
  assign busy         = (state_reg != IDLE);
  assign line_done    = line_done_reg;
  assign overrun      = overrun_reg;

endmodule
